trig_seq_divider: RTL and testbench

TRIG_SEQ_DIVIDER -- requirements
Module: trig_seq_divider

---
 rtl/trig_pkg.sv | 26 ++
 rtl/trig_sync.sv | 34 +++
 rtl/trig_seq_divider.sv | 244 ++++++++++++++++++++++++
 tb/tb_trig_seq_divider.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// ============================================================================
//  Module      : trig_pkg
//  Description : Shared FSM state encoding and default parameter constants for
//                the trigger sequence divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trig_pkg;

    localparam int c_DEF_CTR_W   = 3;
    localparam int c_DEF_N_STRB  = 2;
    localparam int c_DEF_PULSE_W = 8;
    localparam int c_DEF_HOLD_W  = 9;
    localparam int c_DEF_MISS_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_BLOCKED = 2'd3
    } trig_state_t;

endpackage

`default_nettype wire

// File: rtl/trig_sync.sv
// ============================================================================
//  Module      : trig_sync
//  Description : Parametrised-width two-flop synchroniser, cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/trig_seq_divider.sv
// ============================================================================
//  Module      : trig_seq_divider
//  Description : Trigger sequence divider: counts trigger edges through a
//                wrapping slot sequence, emits DAQ trigger and per-channel
//                strobes, with optional holdoff (macro TRIG_HOLDOFF_EN) and
//                DAQ-ready blocking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_seq_divider
    import trig_pkg::*;
#(
    parameter int CTR_W   = c_DEF_CTR_W,
    parameter int N_STRB  = c_DEF_N_STRB,
    parameter int PULSE_W = c_DEF_PULSE_W,
    parameter int HOLD_W  = c_DEF_HOLD_W,
    parameter int MISS_W  = c_DEF_MISS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trig_ext,
    input  logic                     trig_int,
    input  logic                     trig_int_en,
    input  logic                     run,
    input  logic [CTR_W-1:0]         trig_max_cnt,
    input  logic [N_STRB*CTR_W-1:0]  trig_seq_sel,
    input  logic                     trig_blk,
    input  logic                     empty_trig_blk,
    input  logic                     trig_rdy,
    input  logic [HOLD_W-1:0]        hold_len,
    input  logic                     pulse_ctr_clr,
    output logic                     trig_out,
    output logic [N_STRB-1:0]        trig_strb,
    output logic [PULSE_W-1:0]       pulse_ctr,
    output logic [MISS_W-1:0]        miss_ctr,
    output logic                     pile_up,
    output logic                     blocked
);

    localparam int c_SEL_W  = N_STRB * CTR_W;
    localparam int c_SYNC_W = 7 + CTR_W + c_SEL_W;

    logic                r_ext_iob;
    logic                r_int_q;
    logic [c_SYNC_W-1:0] w_sync_in;
    logic [c_SYNC_W-1:0] w_sync_out;

    logic                w_ext_s;
    logic                w_int_en_s;
    logic                w_run_s;
    logic                w_blk_s;
    logic                w_empty_s;
    logic                w_rdy_s;
    logic                w_clr_s;
    logic [CTR_W-1:0]    w_max_s;
    logic [c_SEL_W-1:0]  w_sel_s;

    logic                w_trig_mux;
    logic                r_trig_d;
    logic                r_edge;
    logic                r_rdy_d;
    logic                w_rdy_rise;

    trig_state_t         r_state;
    trig_state_t         w_state_nxt;
    logic [CTR_W-1:0]    r_seq_ctr;
    logic [N_STRB-1:0]   w_strb_hit;
    logic                w_any_hit;
    logic                w_accept;
    logic                w_out_fire;
    logic                w_blk_edge;
    logic                w_live_edge;

    // External trigger lands in a single IOB-packable flop before synchronising
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_iob <= 1'b0;
            r_int_q   <= 1'b0;
        end else begin
            r_ext_iob <= trig_ext;
            r_int_q   <= trig_int;
        end
    end

    assign w_sync_in = {r_ext_iob, trig_int_en, run, trig_blk, empty_trig_blk,
                        trig_rdy, pulse_ctr_clr, trig_max_cnt, trig_seq_sel};

    trig_sync #(
        .W   (c_SYNC_W)
    ) u_sync_ctl (
        .clk (clk),
        .rst (rst),
        .i_d (w_sync_in),
        .o_q (w_sync_out)
    );

    assign {w_ext_s, w_int_en_s, w_run_s, w_blk_s, w_empty_s,
            w_rdy_s, w_clr_s, w_max_s, w_sel_s} = w_sync_out;

`ifdef TRIG_HOLDOFF_EN
    logic [HOLD_W-1:0] w_hold_s;
    logic [HOLD_W-1:0] r_hold_cnt;

    trig_sync #(
        .W   (HOLD_W)
    ) u_sync_hold (
        .clk (clk),
        .rst (rst),
        .i_d (hold_len),
        .o_q (w_hold_s)
    );
`else
    logic w_unused_hold;
    assign w_unused_hold = ^hold_len;
`endif

    assign w_trig_mux = w_int_en_s ? r_int_q : w_ext_s;
    assign w_rdy_rise = w_rdy_s & ~r_rdy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_d <= 1'b0;
            r_edge   <= 1'b0;
            r_rdy_d  <= 1'b0;
        end else begin
            r_trig_d <= w_trig_mux;
            r_edge   <= w_trig_mux & ~r_trig_d;
            r_rdy_d  <= w_rdy_s;
        end
    end

    always_comb begin
        w_strb_hit = '0;
        for (int k = 0; k < N_STRB; k++) begin
            w_strb_hit[k] = (w_sel_s[k*CTR_W +: CTR_W] == r_seq_ctr);
        end
    end

    assign w_any_hit   = |w_strb_hit;
    assign w_accept    = r_edge && (r_state == ST_ARMED) && w_run_s;
    assign w_out_fire  = w_accept && (!w_empty_s || w_any_hit);
    assign w_blk_edge  = r_edge && (r_state == ST_BLOCKED);
    assign w_live_edge = r_edge && ((r_state == ST_ARMED) || (r_state == ST_BLOCKED));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A DAQ-ready rise in the same cycle as a new block keeps the FSM armed
    always_comb begin
        w_state_nxt = r_state;
        if (!w_run_s) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_accept) begin
                        if (w_out_fire && w_blk_s && !w_rdy_rise) begin
                            w_state_nxt = ST_BLOCKED;
                        end
`ifdef TRIG_HOLDOFF_EN
                        else if (w_hold_s != '0) begin
                            w_state_nxt = ST_HOLDOFF;
                        end
`endif
                    end
                end
`ifdef TRIG_HOLDOFF_EN
                ST_HOLDOFF: begin
                    if (r_hold_cnt <= HOLD_W'(1)) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
`endif
                ST_BLOCKED: begin
                    if (w_rdy_rise) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef TRIG_HOLDOFF_EN
    // The accepting cycle counts as the first holdoff cycle, so edges spaced
    // exactly hold_len cycles apart are all accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if ((r_state == ST_ARMED) && (w_state_nxt == ST_HOLDOFF)) begin
            r_hold_cnt <= w_hold_s - 1'b1;
        end else if ((r_state == ST_HOLDOFF) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_ctr <= '0;
            pulse_ctr <= '0;
            miss_ctr  <= '0;
            pile_up   <= 1'b0;
            trig_out  <= 1'b0;
            trig_strb <= '0;
        end else begin
            trig_out  <= w_out_fire;
            trig_strb <= w_accept ? w_strb_hit : '0;

            if (w_live_edge) begin
                r_seq_ctr <= (r_seq_ctr >= w_max_s) ? '0 : r_seq_ctr + 1'b1;
                pile_up   <= ~w_rdy_s;
            end

            if (w_clr_s) begin
                pulse_ctr <= '0;
            end else if (w_live_edge) begin
                pulse_ctr <= pulse_ctr + 1'b1;
            end

            if (w_clr_s) begin
                miss_ctr <= '0;
            end else if (w_blk_edge && (miss_ctr != '1)) begin
                miss_ctr <= miss_ctr + 1'b1;
            end
        end
    end

    assign blocked = (r_state == ST_BLOCKED);

endmodule

`default_nettype wire

// File: tb/tb_trig_seq_divider.sv
// ============================================================================
//  Module      : tb_trig_seq_divider
//  Description : Self-checking bench for trig_seq_divider (table vectors,
//                corner sequences, randomized run against a behavioural model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trig_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig_ext = 1'b0;
    logic       trig_int = 1'b0;
    logic       trig_int_en = 1'b1;
    logic       run = 1'b1;
    logic [2:0] trig_max_cnt = 3'd3;
    logic [5:0] trig_seq_sel = 6'd0;
    logic       trig_blk = 1'b0;
    logic       empty_trig_blk = 1'b0;
    logic       trig_rdy = 1'b1;
    logic [8:0] hold_len = 9'd0;
    logic       pulse_ctr_clr = 1'b0;

    logic       trig_out;
    logic [1:0] trig_strb;
    logic [7:0] pulse_ctr;
    logic [7:0] miss_ctr;
    logic       pile_up;
    logic       blocked;

    logic       t2_out;
    logic [1:0] t2_strb;
    logic [3:0] t2_pulse;
    logic [1:0] t2_miss;
    logic       t2_pile;
    logic       t2_blocked;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_out = 0;
    int cnt_s0  = 0;
    int cnt_s1  = 0;

    always #5 clk = ~clk;

    trig_seq_divider u_dut (
        .clk(clk), .rst(rst), .trig_ext(trig_ext), .trig_int(trig_int),
        .trig_int_en(trig_int_en), .run(run), .trig_max_cnt(trig_max_cnt),
        .trig_seq_sel(trig_seq_sel), .trig_blk(trig_blk),
        .empty_trig_blk(empty_trig_blk), .trig_rdy(trig_rdy), .hold_len(hold_len),
        .pulse_ctr_clr(pulse_ctr_clr), .trig_out(trig_out), .trig_strb(trig_strb),
        .pulse_ctr(pulse_ctr), .miss_ctr(miss_ctr), .pile_up(pile_up), .blocked(blocked)
    );

    trig_seq_divider #(.PULSE_W(4), .MISS_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .trig_ext(trig_ext), .trig_int(trig_int),
        .trig_int_en(trig_int_en), .run(run), .trig_max_cnt(trig_max_cnt),
        .trig_seq_sel(trig_seq_sel), .trig_blk(trig_blk),
        .empty_trig_blk(empty_trig_blk), .trig_rdy(trig_rdy), .hold_len(hold_len),
        .pulse_ctr_clr(pulse_ctr_clr), .trig_out(t2_out), .trig_strb(t2_strb),
        .pulse_ctr(t2_pulse), .miss_ctr(t2_miss), .pile_up(t2_pile), .blocked(t2_blocked)
    );

    always @(negedge clk) begin
        if (trig_out === 1'b1)     cnt_out++;
        if (trig_strb[0] === 1'b1) cnt_s0++;
        if (trig_strb[1] === 1'b1) cnt_s1++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        settle();
    endtask

    task automatic send_pulse(input bit ext);
        @(negedge clk);
        if (ext) trig_ext = 1'b1;
        else     trig_int = 1'b1;
        @(negedge clk);
        trig_ext = 1'b0;
        trig_int = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    task automatic measure_latency(input bit ext, output int first);
        first = -1;
        @(negedge clk);
        if (ext) trig_ext = 1'b1;
        else     trig_int = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                trig_ext = 1'b0;
                trig_int = 1'b0;
            end
            if (trig_out === 1'b1 && first < 0) first = i;
        end
    endtask

    typedef struct {
        int max;
        int sel0;
        int sel1;
        bit empty;
        int n;
        int exp_out;
        int exp_s0;
        int exp_s1;
    } vec_t;

    vec_t vecs[6];

    // behavioural model state
    int m_slot, m_pulse, m_miss, m_max, m_sel0, m_sel1;
    bit m_blocked, m_pile, m_empty, m_blk;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int b_out, b_s0, b_s1, lat, found;
        int e_out, e_s0, e_s1;
        bit new_rdy;

        vecs[0] = '{3, 1, 2, 1'b0, 8, 8, 2, 2};
        vecs[1] = '{3, 1, 2, 1'b1, 8, 4, 2, 2};
        vecs[2] = '{0, 0, 5, 1'b1, 5, 5, 5, 0};
        vecs[3] = '{7, 7, 7, 1'b1, 9, 1, 1, 1};
        vecs[4] = '{2, 3, 4, 1'b1, 6, 0, 0, 0};
        vecs[5] = '{5, 0, 3, 1'b0, 7, 7, 2, 1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_trig_out", trig_out, 0);
        chk("rst_trig_strb", trig_strb, 0);
        chk("rst_pulse_ctr", pulse_ctr, 0);
        chk("rst_miss_ctr", miss_ctr, 0);
        chk("rst_pile_up", pile_up, 0);
        chk("rst_blocked", blocked, 0);
        rst = 1'b0;
        settle();

        // latency of the two trigger paths
        measure_latency(1'b0, lat);
        chk("latency_int", lat, 3);
        trig_int_en = 1'b0;
        settle();
        measure_latency(1'b1, lat);
        chk("latency_ext", lat, 5);
        trig_int_en = 1'b1;

        // table-driven slot/strobe vectors
        for (int v = 0; v < 6; v++) begin
            trig_max_cnt   = 3'(vecs[v].max);
            trig_seq_sel   = {3'(vecs[v].sel1), 3'(vecs[v].sel0)};
            empty_trig_blk = vecs[v].empty;
            trig_blk = 1'b0;
            trig_rdy = 1'b1;
            do_reset();
            b_out = cnt_out; b_s0 = cnt_s0; b_s1 = cnt_s1;
            for (int p = 0; p < vecs[v].n; p++) send_pulse(1'b0);
            chk($sformatf("vec%0d_trig_out", v), cnt_out - b_out, vecs[v].exp_out);
            chk($sformatf("vec%0d_strb0", v), cnt_s0 - b_s0, vecs[v].exp_s0);
            chk($sformatf("vec%0d_strb1", v), cnt_s1 - b_s1, vecs[v].exp_s1);
            chk($sformatf("vec%0d_pulse_ctr", v), pulse_ctr, vecs[v].n);
        end

        // external triggers 1000 cycles apart, max=3, sel={1,2}
        trig_max_cnt = 3'd3;
        trig_seq_sel = {3'd2, 3'd1};
        empty_trig_blk = 1'b0;
        trig_int_en = 1'b0;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            b_s0 = cnt_s0; b_s1 = cnt_s1;
            @(negedge clk);
            trig_ext = 1'b1;
            @(negedge clk);
            trig_ext = 1'b0;
            repeat (998) @(negedge clk);
            chk($sformatf("ext_pat%0d_strb0", p), cnt_s0 - b_s0, (p % 4 == 1) ? 1 : 0);
            chk($sformatf("ext_pat%0d_strb1", p), cnt_s1 - b_s1, (p % 4 == 2) ? 1 : 0);
        end
        trig_int_en = 1'b1;

        // holdoff: 4 internal pulses 50 cycles apart with hold_len=100
        hold_len = 9'd100;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            trig_int = 1'b1;
            @(negedge clk);
            trig_int = 1'b0;
            repeat (48) @(negedge clk);
        end
        settle();
`ifdef TRIG_HOLDOFF_EN
        chk("holdoff_pulse_ctr", pulse_ctr, 2);
`else
        chk("holdoff_pulse_ctr", pulse_ctr, 4);
`endif
        hold_len = 9'd0;

        // blocking while DAQ not ready
        trig_blk = 1'b1;
        trig_rdy = 1'b0;
        empty_trig_blk = 1'b0;
        do_reset();
        b_out = cnt_out;
        repeat (3) send_pulse(1'b0);
        chk("blk_trig_out", cnt_out - b_out, 1);
        chk("blk_blocked", blocked, 1);
        chk("blk_miss_ctr", miss_ctr, 2);
        chk("blk_pile_up", pile_up, 1);
        repeat (3) send_pulse(1'b0);
        chk("blk_miss5", miss_ctr, 5);
        chk("blk_miss_sat", t2_miss, 3);
        chk("blk_out_stays", cnt_out - b_out, 1);
        @(negedge clk);
        trig_rdy = 1'b1;
        found = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (blocked === 1'b0 && found < 0) found = i;
        end
        chk("unblock_within4", (found >= 1) ? 1 : 0, 1);
        settle();
        b_out = cnt_out;
        send_pulse(1'b0);
        chk("reblock_trig_out", cnt_out - b_out, 1);
        chk("reblock_blocked", blocked, 1);

        // reset in the middle of BLOCKED
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_trig_out", trig_out, 0);
        chk("midrst_strb", trig_strb, 0);
        chk("midrst_pulse", pulse_ctr, 0);
        chk("midrst_miss", miss_ctr, 0);
        chk("midrst_pile", pile_up, 0);
        chk("midrst_blocked", blocked, 0);
        rst = 1'b0;
        trig_blk = 1'b0;
        trig_seq_sel = {3'd5, 3'd0};
        empty_trig_blk = 1'b1;
        settle();
        b_s0 = cnt_s0; b_out = cnt_out;
        send_pulse(1'b0);
        chk("midrst_slot0_strb0", cnt_s0 - b_s0, 1);
        chk("midrst_slot0_out", cnt_out - b_out, 1);

        // pulse counter wrap on the 4-bit instance
        empty_trig_blk = 1'b0;
        do_reset();
        repeat (17) send_pulse(1'b0);
        chk("wrap_pulse4", t2_pulse, 1);
        chk("wrap_pulse8", pulse_ctr, 17);

        // clear of both counters
        @(negedge clk);
        pulse_ctr_clr = 1'b1;
        @(negedge clk);
        pulse_ctr_clr = 1'b0;
        settle();
        chk("clr_pulse", pulse_ctr, 0);

        // ready rise coinciding with a blocking trigger: unblock wins
        trig_blk = 1'b1;
        trig_rdy = 1'b0;
        do_reset();
        b_out = cnt_out;
        @(negedge clk);
        trig_int = 1'b1;
        trig_rdy = 1'b1;
        @(negedge clk);
        trig_int = 1'b0;
        repeat (8) @(negedge clk);
        chk("tie_trig_out", cnt_out - b_out, 1);
        chk("tie_blocked", blocked, 0);
        chk("tie_pile_up", pile_up, 0);

        // randomized run against the behavioural model
        trig_blk = 1'b0;
        trig_rdy = 1'b1;
        do_reset();
        m_slot = 0; m_pulse = 0; m_miss = 0; m_blocked = 1'b0; m_pile = 1'b0;
        m_max = 3; m_sel0 = 0; m_sel1 = 5; m_empty = 1'b0; m_blk = 1'b0;
        for (int it = 0; it < 90; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                m_max = $urandom_range(0, 7);
                m_sel0 = $urandom_range(0, 7);
                m_sel1 = $urandom_range(0, 7);
                m_empty = $urandom_range(0, 1);
                m_blk = ($urandom_range(0, 2) == 0);
            end
            trig_max_cnt = 3'(m_max);
            trig_seq_sel = {3'(m_sel1), 3'(m_sel0)};
            empty_trig_blk = m_empty;
            trig_blk = m_blk;
            if ($urandom_range(0, 2) == 0) begin
                new_rdy = $urandom_range(0, 1);
                if (new_rdy && !trig_rdy) m_blocked = 1'b0;
                trig_rdy = new_rdy;
            end
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                pulse_ctr_clr = 1'b1;
                @(negedge clk);
                pulse_ctr_clr = 1'b0;
                m_pulse = 0;
                m_miss = 0;
            end
            settle();

            e_out = 0; e_s0 = 0; e_s1 = 0;
            if (!m_blocked) begin
                e_s0 = (m_slot == m_sel0) ? 1 : 0;
                e_s1 = (m_slot == m_sel1) ? 1 : 0;
                e_out = (!m_empty || e_s0 == 1 || e_s1 == 1) ? 1 : 0;
                if (e_out == 1 && m_blk) m_blocked = 1'b1;
            end else begin
                m_miss++;
            end
            m_pulse++;
            m_pile = !trig_rdy;
            m_slot = (m_slot >= m_max) ? 0 : m_slot + 1;

            b_out = cnt_out; b_s0 = cnt_s0; b_s1 = cnt_s1;
            send_pulse(1'b0);
            chk($sformatf("rnd%0d_out", it), cnt_out - b_out, e_out);
            chk($sformatf("rnd%0d_strb0", it), cnt_s0 - b_s0, e_s0);
            chk($sformatf("rnd%0d_strb1", it), cnt_s1 - b_s1, e_s1);
            chk($sformatf("rnd%0d_blocked", it), blocked, m_blocked);
            chk($sformatf("rnd%0d_pile", it), pile_up, m_pile);
            chk($sformatf("rnd%0d_pulse8", it), pulse_ctr, m_pulse % 256);
            chk($sformatf("rnd%0d_pulse4", it), t2_pulse, m_pulse % 16);
            chk($sformatf("rnd%0d_miss8", it), miss_ctr, (m_miss > 255) ? 255 : m_miss);
            chk($sformatf("rnd%0d_miss2", it), t2_miss, (m_miss > 3) ? 3 : m_miss);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
